// File: rtl/wfg_timer.sv
// wfg_timer: Wishbone-mapped 32-bit timer/counter with a 16-bit prescaler,
// compare match, periodic or one-shot operation and a level interrupt.
module wfg_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        interrupt_o
);

    typedef enum logic [5:0] {
        REG_CTRL     = 6'd0,
        REG_STATUS   = 6'd1,
        REG_PRESCALE = 6'd2,
        REG_COMPARE  = 6'd3,
        REG_COUNT    = 6'd4
    } reg_e;

    // CTRL bits: [0] EN, [1] IE, [2] PER
    logic [2:0]  ctrl_q, ctrl_d;
    logic        pend_q, pend_d;
    logic [15:0] prescale_q, prescale_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] count_q, count_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic        irq_q, irq_d;

    logic [5:0]  word_adr;
    logic        req, wr, rd;
    logic        wr_ctrl, wr_status, wr_prescale, wr_compare, wr_count;
    logic        tick, match;
    logic        unused_adr;

    assign word_adr   = wbs_adr_i[7:2];
    // Upper address bits are decoded externally; byte-lane bits are meaningless
    assign unused_adr = ^{wbs_adr_i[31:8], wbs_adr_i[1:0]};

    // Bus request qualification and per-register write strobes
    always_comb begin
        req         = wbs_stb_i & wbs_cyc_i & ~ack_q;
        wr          = req & wbs_we_i;
        rd          = req & ~wbs_we_i;
        wr_ctrl     = wr && (word_adr == REG_CTRL);
        wr_status   = wr && (word_adr == REG_STATUS);
        wr_prescale = wr && (word_adr == REG_PRESCALE);
        wr_compare  = wr && (word_adr == REG_COMPARE);
        wr_count    = wr && (word_adr == REG_COUNT);
    end

    // Prescaler tick and compare match detection
    always_comb begin
        tick  = ctrl_q[0] && (pcnt_q == prescale_q);
        match = tick && (count_q == compare_q);
    end

    // Next-state for timer registers; bus writes and set-over-clear ordering
    always_comb begin
        pcnt_d = (!ctrl_q[0] || tick) ? '0 : pcnt_q + 16'd1;

        count_d = count_q;
        if (wr_count) begin
            count_d = wbs_dat_i;
        end else if (tick) begin
            if (!match) begin
                count_d = count_q + 32'd1;
            end else if (ctrl_q[2]) begin
                count_d = '0;
            end
        end

        ctrl_d = ctrl_q;
        if (match && !ctrl_q[2]) begin
            ctrl_d[0] = 1'b0;
        end
        if (wr_ctrl) begin
            ctrl_d = wbs_dat_i[2:0];
        end

        pend_d = pend_q;
        if (wr_status && wbs_dat_i[0]) begin
            pend_d = 1'b0;
        end
        if (match) begin
            pend_d = 1'b1;
        end

        prescale_d = wr_prescale ? wbs_dat_i[15:0] : prescale_q;
        compare_d  = wr_compare  ? wbs_dat_i       : compare_q;

        // Interrupt follows the post-edge PEND/IE so it moves on the same edge
        irq_d = pend_d & ctrl_d[1];
        ack_d = req;
    end

    // Read mux: data reflects register state before the ack edge
    always_comb begin
        rdata_d = '0;
        if (rd) begin
            case (word_adr)
                REG_CTRL:     rdata_d = {29'd0, ctrl_q};
                REG_STATUS:   rdata_d = {31'd0, pend_q};
                REG_PRESCALE: rdata_d = {16'd0, prescale_q};
                REG_COMPARE:  rdata_d = compare_q;
                REG_COUNT:    rdata_d = count_q;
                default:      rdata_d = '0;
            endcase
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q     <= '0;
            pend_q     <= 1'b0;
            prescale_q <= '0;
            compare_q  <= '0;
            count_q    <= '0;
            pcnt_q     <= '0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            pend_q     <= pend_d;
            prescale_q <= prescale_d;
            compare_q  <= compare_d;
            count_q    <= count_d;
            pcnt_q     <= pcnt_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = rdata_q;
    assign interrupt_o = irq_q;

endmodule

// File: tb/tb_wfg_timer.sv
// tb_wfg_timer: scoreboard-based bench for the wfg_timer peripheral.
module tb_wfg_timer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb, cyc, we;
    logic [31:0] dat_i, adr;
    logic        ack;
    logic [31:0] dat_o;
    logic        irq;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cycle = 0;

    wfg_timer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_dat_i  (dat_i),
        .wbs_adr_i  (adr),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (dat_o),
        .interrupt_o(irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Bus tasks are entered and left 1 time unit after a rising edge.
    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = a; dat_i = d;
        do begin
            @(posedge clk); #1; n++;
        end while (ack !== 1'b1 && n < 8);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        total++;
        if (ack !== 1'b1) begin
            bad++;
            $display("FAIL write_ack adr=%h: ack=%b, expected 1", a, ack);
        end
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        int n = 0;
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = a;
        do begin
            @(posedge clk); #1; n++;
        end while (ack !== 1'b1 && n < 8);
        d = dat_o;
        stb = 1'b0; cyc = 1'b0;
        total++;
        if (ack !== 1'b1) begin
            bad++;
            $display("FAIL read_ack adr=%h: ack=%b, expected 1", a, ack);
        end
    endtask

    task automatic wait_irq(output int t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            if (irq === 1'b1) begin
                t  = cycle;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] got;
        exp_t e;
        rst_n = 1'b0; stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = '0; dat_i = '0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            total++;
            if (ack !== 1'b0) begin
                bad++;
                $display("FAIL reset_ack cycle %0d: ack=%b, expected 0", i, ack);
            end
        end
        rst_n = 1'b1; stb = 1'b0; cyc = 1'b0;
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL reset_irq: irq=%b, expected 0", irq);
        end
        for (int i = 0; i < 16; i++) sb.push_back('{$sformatf("reset_read_%02h", i * 4), 32'd0});
        for (int i = 0; i < 16; i++) begin
            wb_read(32'(i * 4), got);
            e = sb.pop_front();
            total++;
            if (got !== e.exp) begin
                bad++;
                $display("FAIL %s: got %h, expected %h", e.name, got, e.exp);
            end
            @(posedge clk); #1;
            total++;
            if (ack !== 1'b0) begin
                bad++;
                $display("FAIL %s_ack_width: ack=%b one cycle after ack, expected 0", e.name, ack);
            end
        end
    endtask

    task automatic test_regs();
        logic [31:0] got;
        exp_t e;
        wb_write(32'h0C, 32'hDEADBEEF);
        sb.push_back('{"compare_rw", 32'hDEADBEEF});
        wb_read(32'h0C, got);
        e = sb.pop_front(); total++;
        if (got !== e.exp) begin bad++; $display("FAIL %s: got %h, expected %h", e.name, got, e.exp); end

        wb_write(32'h08, 32'hFFFF1234);
        sb.push_back('{"prescale_rw", 32'h00001234});
        wb_read(32'h08, got);
        e = sb.pop_front(); total++;
        if (got !== e.exp) begin bad++; $display("FAIL %s: got %h, expected %h", e.name, got, e.exp); end

        wb_write(32'h3C, 32'hFFFFFFFF);
        sb.push_back('{"unmapped_3c", 32'd0});
        wb_read(32'h3C, got);
        e = sb.pop_front(); total++;
        if (got !== e.exp) begin bad++; $display("FAIL %s: got %h, expected %h", e.name, got, e.exp); end

        // Upper and byte-lane address bits must be ignored
        sb.push_back('{"compare_alias_adr", 32'hDEADBEEF});
        wb_read(32'hABCDE00F, got);
        e = sb.pop_front(); total++;
        if (got !== e.exp) begin bad++; $display("FAIL %s: got %h, expected %h", e.name, got, e.exp); end

        wb_write(32'h08, 32'd0);
        wb_write(32'h0C, 32'd0);
    endtask

    task automatic test_periodic();
        logic [31:0] got;
        exp_t e;
        int t0, t1, t2;
        bit ok;
        wb_write(32'h00, 32'd0);
        wb_write(32'h08, 32'd0);
        wb_write(32'h0C, 32'd4);
        wb_write(32'h10, 32'd0);
        wb_write(32'h00, 32'h7);
        t0 = cycle;
        wait_irq(t1, ok);
        total++;
        if (!ok || (t1 - t0) != 5) begin
            bad++;
            $display("FAIL periodic_first_match: cycles=%0d (seen=%0b), expected 5", t1 - t0, ok);
        end
        sb.push_back('{"periodic_count_after_match", 32'd0});
        wb_read(32'h10, got);
        e = sb.pop_front(); total++;
        if (got !== e.exp) begin bad++; $display("FAIL %s: got %h, expected %h", e.name, got, e.exp); end

        wb_write(32'h04, 32'd1);
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL periodic_w1c_irq: irq=%b, expected 0", irq);
        end
        wait_irq(t2, ok);
        total++;
        if (!ok || (t2 - t1) != 5) begin
            bad++;
            $display("FAIL periodic_second_match: period=%0d (seen=%0b), expected 5", t2 - t1, ok);
        end
        wb_write(32'h00, 32'd0);
        wb_write(32'h04, 32'd1);
    endtask

    task automatic test_oneshot();
        logic [31:0] got;
        exp_t e;
        int t0, t1;
        bit ok;
        wb_write(32'h10, 32'd0);
        wb_write(32'h08, 32'd2);
        wb_write(32'h0C, 32'd3);
        wb_write(32'h00, 32'h3);
        t0 = cycle;
        wait_irq(t1, ok);
        total++;
        if (!ok || (t1 - t0) != 12) begin
            bad++;
            $display("FAIL oneshot_match: cycles=%0d (seen=%0b), expected 12", t1 - t0, ok);
        end
        sb.push_back('{"oneshot_ctrl", 32'h2});
        sb.push_back('{"oneshot_count", 32'd3});
        sb.push_back('{"oneshot_count_later", 32'd3});
        sb.push_back('{"oneshot_status", 32'd1});
        wb_read(32'h00, got);
        e = sb.pop_front(); total++;
        if (got !== e.exp) begin bad++; $display("FAIL %s: got %h, expected %h", e.name, got, e.exp); end
        wb_read(32'h10, got);
        e = sb.pop_front(); total++;
        if (got !== e.exp) begin bad++; $display("FAIL %s: got %h, expected %h", e.name, got, e.exp); end
        repeat (20) @(posedge clk);
        #1;
        wb_read(32'h10, got);
        e = sb.pop_front(); total++;
        if (got !== e.exp) begin bad++; $display("FAIL %s: got %h, expected %h", e.name, got, e.exp); end
        wb_read(32'h04, got);
        e = sb.pop_front(); total++;
        if (got !== e.exp) begin bad++; $display("FAIL %s: got %h, expected %h", e.name, got, e.exp); end
        wb_write(32'h00, 32'd0);
        wb_write(32'h04, 32'd1);
    endtask

    task automatic test_wrap();
        int t0, t1;
        bit ok;
        wb_write(32'h08, 32'd0);
        wb_write(32'h0C, 32'd2);
        wb_write(32'h10, 32'hFFFFFFFE);
        wb_write(32'h00, 32'h7);
        t0 = cycle;
        wait_irq(t1, ok);
        total++;
        if (!ok || (t1 - t0) != 5) begin
            bad++;
            $display("FAIL wrap_match: cycles=%0d (seen=%0b), expected 5", t1 - t0, ok);
        end
        wb_write(32'h00, 32'd0);
        wb_write(32'h04, 32'd1);
    endtask

    task automatic test_collision();
        logic [31:0] got;
        exp_t e;
        // COUNT write on a tick edge: PRESCALE=3 puts ticks 4, 8, ... edges after EN
        wb_write(32'h08, 32'd3);
        wb_write(32'h0C, 32'd1000);
        wb_write(32'h10, 32'd0);
        wb_write(32'h00, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        wb_write(32'h10, 32'd100);
        sb.push_back('{"count_write_vs_tick", 32'd100});
        wb_read(32'h10, got);
        e = sb.pop_front(); total++;
        if (got !== e.exp) begin bad++; $display("FAIL %s: got %h, expected %h", e.name, got, e.exp); end

        // W1C on a match edge: periodic period 5, matches 5 and 10 edges after EN
        wb_write(32'h00, 32'd0);
        wb_write(32'h08, 32'd0);
        wb_write(32'h0C, 32'd4);
        wb_write(32'h10, 32'd0);
        wb_write(32'h04, 32'd1);
        wb_write(32'h00, 32'h7);
        repeat (9) @(posedge clk);
        #1;
        wb_write(32'h04, 32'd1);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL w1c_vs_match_irq: irq=%b, expected 1", irq);
        end
        sb.push_back('{"w1c_vs_match_pend", 32'd1});
        wb_read(32'h04, got);
        e = sb.pop_front(); total++;
        if (got !== e.exp) begin bad++; $display("FAIL %s: got %h, expected %h", e.name, got, e.exp); end
        wb_write(32'h00, 32'd0);
        wb_write(32'h04, 32'd1);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int acks = 0;
        wb_write(32'h0C, 32'h5A5AA5A5);
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h0C;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) begin
                acks++;
                sb.push_back('{$sformatf("held_read_%0d", i), 32'h5A5AA5A5});
                e = sb.pop_front(); total++;
                if (dat_o !== e.exp) begin bad++; $display("FAIL %s: got %h, expected %h", e.name, dat_o, e.exp); end
            end else begin
                total++;
                if (dat_o !== 32'd0) begin
                    bad++;
                    $display("FAIL held_idle_data_%0d: dat_o=%h with ack low, expected 0", i, dat_o);
                end
            end
        end
        stb = 1'b0; cyc = 1'b0;
        total++;
        if (acks != 3) begin
            bad++;
            $display("FAIL held_ack_count: acks=%0d, expected 3", acks);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] got;
        exp_t e;
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h0C; rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            total++;
            if (ack !== 1'b0 || dat_o !== 32'd0) begin
                bad++;
                $display("FAIL abort_%0d: ack=%b dat_o=%h, expected ack 0 data 0", i, ack, dat_o);
            end
        end
        stb = 1'b0; cyc = 1'b0; rst_n = 1'b1;
        sb.push_back('{"abort_compare_cleared", 32'd0});
        wb_read(32'h0C, got);
        e = sb.pop_front(); total++;
        if (got !== e.exp) begin bad++; $display("FAIL %s: got %h, expected %h", e.name, got, e.exp); end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_periodic();
        test_oneshot();
        test_wrap();
        test_collision();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
